// File: rtl/cdb_reservation_station_if.sv
// Common data bus as seen by its producers (arbiter side) and consumers.
// The reservation station only snoops: result, robEntry and validBroadcast are inputs to it.
interface commonDataBus #(
    parameter int WIDTH = 31,
    parameter int ROB   = 2
);
    logic [WIDTH:0] result;
    logic [ROB:0]   robEntry;
    logic           validBroadcast;

    modport reservation_station (input result, robEntry, validBroadcast);
    modport arbiter (output result, robEntry, validBroadcast);
endinterface

// File: rtl/cdb_reservation_station.sv
// Reservation station: buffers dispatched ops, wakes operands from CDB broadcasts, issues to one FU.
// Optional macro RS_AGE_ORDER_EN selects oldest-first issue; otherwise lowest-index-first.
module cdb_reservation_station #(
    parameter int WIDTH   = 31,
    parameter int ROB     = 2,
    parameter int CONTROL = 6,
    parameter int ENTRIES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 dispatchValid,
    input  logic [CONTROL:0]     dispatchOp,
    input  logic [ROB:0]         dispatchRob,
    input  logic [WIDTH:0]       src1Value,
    input  logic [WIDTH:0]       src2Value,
    input  logic [ROB:0]         src1Tag,
    input  logic [ROB:0]         src2Tag,
    input  logic                 src1Ready,
    input  logic                 src2Ready,
    output logic                 full,
    commonDataBus.reservation_station dataBus,
    input  logic                 issueReady,
    output logic                 issueValid,
    output logic [CONTROL:0]     issueOp,
    output logic [ROB:0]         issueRob,
    output logic [WIDTH:0]       issueOperand1,
    output logic [WIDTH:0]       issueOperand2
);
    localparam int IDX_W = $clog2(ENTRIES);

    typedef struct packed {
        logic             valid;
        logic [CONTROL:0] op;
        logic [ROB:0]     rob;
        logic [WIDTH:0]   val1;
        logic [ROB:0]     tag1;
        logic             rdy1;
        logic [WIDTH:0]   val2;
        logic [ROB:0]     tag2;
        logic             rdy2;
`ifdef RS_AGE_ORDER_EN
        logic [IDX_W-1:0] age;
`endif
    } entry_t;

    entry_t           ent_q [ENTRIES];
    entry_t           ent_d [ENTRIES];
    entry_t           new_ent;
    logic             issue_valid_q, issue_valid_d;
    logic [CONTROL:0] issue_op_q, issue_op_d;
    logic [ROB:0]     issue_rob_q, issue_rob_d;
    logic [WIDTH:0]   issue_opnd1_q, issue_opnd1_d;
    logic [WIDTH:0]   issue_opnd2_q, issue_opnd2_d;
    logic             sel_found;
    logic [IDX_W-1:0] sel_idx, free_idx;
    logic             do_dispatch, issue_load;

    always_comb begin
        full = 1'b1;
        for (int i = 0; i < ENTRIES; i++)
            if (!ent_q[i].valid) full = 1'b0;
    end

    // Select and free-slot search both work on the registered state only.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        free_idx  = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (ent_q[i].valid && ent_q[i].rdy1 && ent_q[i].rdy2) begin
`ifdef RS_AGE_ORDER_EN
                if (!sel_found || ent_q[i].age > ent_q[sel_idx].age) begin
`else
                if (!sel_found) begin
`endif
                    sel_found = 1'b1;
                    sel_idx   = IDX_W'(i);
                end
            end
        end
        for (int i = ENTRIES - 1; i >= 0; i--)
            if (!ent_q[i].valid) free_idx = IDX_W'(i);
    end

    // Incoming entry, with same-cycle broadcast bypass on each operand.
    always_comb begin
        new_ent       = '0;
        new_ent.valid = 1'b1;
        new_ent.op    = dispatchOp;
        new_ent.rob   = dispatchRob;
        new_ent.val1  = src1Value;
        new_ent.tag1  = src1Tag;
        new_ent.rdy1  = src1Ready;
        new_ent.val2  = src2Value;
        new_ent.tag2  = src2Tag;
        new_ent.rdy2  = src2Ready;
        if (!src1Ready && dataBus.validBroadcast && src1Tag == dataBus.robEntry) begin
            new_ent.val1 = dataBus.result;
            new_ent.rdy1 = 1'b1;
        end
        if (!src2Ready && dataBus.validBroadcast && src2Tag == dataBus.robEntry) begin
            new_ent.val2 = dataBus.result;
            new_ent.rdy2 = 1'b1;
        end
    end

    always_comb begin
        ent_d         = ent_q;
        issue_valid_d = issue_valid_q;
        issue_op_d    = issue_op_q;
        issue_rob_d   = issue_rob_q;
        issue_opnd1_d = issue_opnd1_q;
        issue_opnd2_d = issue_opnd2_q;
        do_dispatch   = dispatchValid && !full;
        issue_load    = !issue_valid_q || issueReady;

        for (int i = 0; i < ENTRIES; i++) begin
            if (ent_q[i].valid && dataBus.validBroadcast) begin
                if (!ent_q[i].rdy1 && ent_q[i].tag1 == dataBus.robEntry) begin
                    ent_d[i].val1 = dataBus.result;
                    ent_d[i].rdy1 = 1'b1;
                end
                if (!ent_q[i].rdy2 && ent_q[i].tag2 == dataBus.robEntry) begin
                    ent_d[i].val2 = dataBus.result;
                    ent_d[i].rdy2 = 1'b1;
                end
            end
`ifdef RS_AGE_ORDER_EN
            if (do_dispatch && ent_q[i].valid && ent_q[i].age != '1)
                ent_d[i].age = ent_q[i].age + 1'b1;
`endif
        end

        if (issue_load) begin
            issue_valid_d = sel_found;
            if (sel_found) begin
                issue_op_d           = ent_q[sel_idx].op;
                issue_rob_d          = ent_q[sel_idx].rob;
                issue_opnd1_d        = ent_q[sel_idx].val1;
                issue_opnd2_d        = ent_q[sel_idx].val2;
                ent_d[sel_idx].valid = 1'b0;
            end
        end

        // The free slot was found among currently invalid entries, so it never aliases sel_idx.
        if (do_dispatch) ent_d[free_idx] = new_ent;

        if (flush) begin
            for (int i = 0; i < ENTRIES; i++) ent_d[i].valid = 1'b0;
            issue_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) ent_q[i] <= '0;
            issue_valid_q <= 1'b0;
            issue_op_q    <= '0;
            issue_rob_q   <= '0;
            issue_opnd1_q <= '0;
            issue_opnd2_q <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) ent_q[i] <= ent_d[i];
            issue_valid_q <= issue_valid_d;
            issue_op_q    <= issue_op_d;
            issue_rob_q   <= issue_rob_d;
            issue_opnd1_q <= issue_opnd1_d;
            issue_opnd2_q <= issue_opnd2_d;
        end
    end

    assign issueValid    = issue_valid_q;
    assign issueOp       = issue_op_q;
    assign issueRob      = issue_rob_q;
    assign issueOperand1 = issue_opnd1_q;
    assign issueOperand2 = issue_opnd2_q;
endmodule

// File: tb/tb_cdb_reservation_station.sv
// Directed bench for cdb_reservation_station: a slot-level model checked every cycle,
// plus hand-computed literal expectations at key points of each scenario.
module tb_cdb_reservation_station;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        reset, flush, dispatchValid, src1Ready, src2Ready, issueReady;
    logic [6:0]  dispatchOp;
    logic [2:0]  dispatchRob, src1Tag, src2Tag;
    logic [31:0] src1Value, src2Value;
    logic        full, issueValid;
    logic [6:0]  issueOp;
    logic [2:0]  issueRob;
    logic [31:0] issueOperand1, issueOperand2;

    commonDataBus #(.WIDTH(31), .ROB(2)) cdb ();

    cdb_reservation_station dut (
        .clk(clk), .reset(reset), .flush(flush),
        .dispatchValid(dispatchValid), .dispatchOp(dispatchOp), .dispatchRob(dispatchRob),
        .src1Value(src1Value), .src2Value(src2Value), .src1Tag(src1Tag), .src2Tag(src2Tag),
        .src1Ready(src1Ready), .src2Ready(src2Ready), .full(full), .dataBus(cdb),
        .issueReady(issueReady), .issueValid(issueValid), .issueOp(issueOp), .issueRob(issueRob),
        .issueOperand1(issueOperand1), .issueOperand2(issueOperand2)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 1'b0;

    // Model state: one record per slot, ages derived from dispatch counts.
    bit          m_valid [N];
    logic [6:0]  m_op [N];
    logic [2:0]  m_rob [N];
    logic [31:0] m_v1 [N], m_v2 [N];
    logic [2:0]  m_t1 [N], m_t2 [N];
    bit          m_r1 [N], m_r2 [N];
    int unsigned m_stamp [N];
    int unsigned disp_cnt;
    bit          m_iv;
    logic [6:0]  m_iop;
    logic [2:0]  m_irob;
    logic [31:0] m_io1, m_io2;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int unsigned age_of(input int i);
        int unsigned d = disp_cnt - m_stamp[i];
        return (d > N - 1) ? N - 1 : d;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) m_valid[i] = 0;
        m_iv = 0; m_iop = '0; m_irob = '0; m_io1 = '0; m_io2 = '0;
        disp_cnt = 0;
    endtask

    task automatic model_edge();
        bit was_full = 1;
        int sel = -1;
        int slot = -1;
        if (flush) begin
            for (int i = 0; i < N; i++) m_valid[i] = 0;
            m_iv = 0;
            return;
        end
        for (int i = 0; i < N; i++) begin
            if (!m_valid[i]) begin
                was_full = 0;
                if (slot < 0) slot = i;
            end
            if (m_valid[i] && m_r1[i] && m_r2[i]) begin
`ifdef RS_AGE_ORDER_EN
                if (sel < 0 || age_of(i) > age_of(sel)) sel = i;
`else
                if (sel < 0) sel = i;
`endif
            end
        end
        if (!m_iv || issueReady) begin
            m_iv = (sel >= 0);
            if (sel >= 0) begin
                m_iop = m_op[sel]; m_irob = m_rob[sel]; m_io1 = m_v1[sel]; m_io2 = m_v2[sel];
                m_valid[sel] = 0;
            end
        end
        if (dispatchValid && !was_full) begin
            m_valid[slot] = 1; m_op[slot] = dispatchOp; m_rob[slot] = dispatchRob;
            m_v1[slot] = src1Value; m_t1[slot] = src1Tag; m_r1[slot] = src1Ready;
            m_v2[slot] = src2Value; m_t2[slot] = src2Tag; m_r2[slot] = src2Ready;
            disp_cnt++;
            m_stamp[slot] = disp_cnt;
        end
        // A broadcast reaches every waiting operand, including one dispatched this edge (bypass).
        if (cdb.validBroadcast)
            for (int i = 0; i < N; i++)
                if (m_valid[i]) begin
                    if (!m_r1[i] && m_t1[i] == cdb.robEntry) begin m_v1[i] = cdb.result; m_r1[i] = 1; end
                    if (!m_r2[i] && m_t2[i] == cdb.robEntry) begin m_v2[i] = cdb.result; m_r2[i] = 1; end
                end
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_clear(); else model_edge();
        #1;
    endtask

    task automatic idle();
        dispatchValid = 0; flush = 0; cdb.validBroadcast = 0;
    endtask

    task automatic disp(input logic [6:0] op, input logic [2:0] rob,
                        input logic [31:0] v1, input logic [2:0] t1, input logic r1,
                        input logic [31:0] v2, input logic [2:0] t2, input logic r2);
        dispatchValid = 1; dispatchOp = op; dispatchRob = rob;
        src1Value = v1; src1Tag = t1; src1Ready = r1;
        src2Value = v2; src2Tag = t2; src2Ready = r2;
    endtask

    task automatic bcast(input logic [2:0] tag, input logic [31:0] res);
        cdb.validBroadcast = 1; cdb.robEntry = tag; cdb.result = res;
    endtask

    always @(negedge clk) begin
        if (started && !reset) begin
            chk("mdl_full", full, {63'd0, (m_valid[0] & m_valid[1] & m_valid[2] & m_valid[3])});
            chk("mdl_issueValid", issueValid, {63'd0, m_iv});
            if (m_iv) begin
                chk("mdl_issueOp", issueOp, m_iop);
                chk("mdl_issueRob", issueRob, m_irob);
                chk("mdl_operand1", issueOperand1, m_io1);
                chk("mdl_operand2", issueOperand2, m_io2);
            end
        end
    end

    initial begin
        reset = 1; issueReady = 1; src1Ready = 0; src2Ready = 0;
        dispatchOp = '0; dispatchRob = '0; src1Value = '0; src2Value = '0; src1Tag = '0; src2Tag = '0;
        cdb.robEntry = '0; cdb.result = '0;
        idle();
        model_clear();
        tick(); tick();
        chk("rst_issueValid", issueValid, 0);
        chk("rst_full", full, 0);
        chk("rst_issueOp", issueOp, 0);
        chk("rst_issueRob", issueRob, 0);
        chk("rst_operands", {issueOperand1, issueOperand2}, 0);
        reset = 0; started = 1;

        // Both operands ready: issue one edge after dispatch.
        disp(5, 3, 10, 0, 1, 20, 0, 1); tick();
        idle(); chk("t1_not_yet", issueValid, 0);
        tick();
        chk("t1_valid", issueValid, 1); chk("t1_op", issueOp, 5); chk("t1_rob", issueRob, 3);
        chk("t1_opnd1", issueOperand1, 10); chk("t1_opnd2", issueOperand2, 20); chk("t1_full", full, 0);
        tick();

        // Wakeup from a later broadcast.
        disp(2, 1, 0, 6, 0, 4, 0, 1); tick();
        idle(); tick();
        bcast(6, 32'hDEAD); tick();
        idle(); chk("t2_wait", issueValid, 0);
        tick();
        chk("t2_valid", issueValid, 1); chk("t2_rob", issueRob, 1); chk("t2_opnd1", issueOperand1, 32'hDEAD);
        tick();

        // Same-cycle bypass.
        disp(3, 4, 0, 2, 0, 1, 0, 1); bcast(2, 7); tick();
        idle(); tick();
        chk("t3_valid", issueValid, 1); chk("t3_opnd1", issueOperand1, 7);
        tick();

        // One broadcast wakes both operands of an entry.
        disp(4, 5, 0, 3, 0, 0, 3, 0); tick();
        idle(); bcast(3, 32'h33); tick();
        idle(); tick();
        chk("dual_opnds", {issueOperand1, issueOperand2}, {32'h33, 32'h33});
        tick();

        // Fill, drop a fifth dispatch, free slot 0 by wakeup, refill it.
        disp(1, 0, 0, 5, 0, 1, 0, 1); tick();
        disp(1, 1, 0, 6, 0, 1, 0, 1); tick();
        disp(1, 2, 0, 7, 0, 1, 0, 1); tick();
        disp(1, 3, 0, 0, 0, 1, 0, 1); tick();
        chk("t4_full", full, 1);
        disp(1, 5, 9, 0, 1, 9, 0, 1); tick();
        chk("t4_drop_full", full, 1); chk("t4_drop_iv", issueValid, 0);
        idle(); bcast(5, 32'h55); tick();
        idle(); tick();
        chk("t4_iv", issueValid, 1); chk("t4_rob", issueRob, 0); chk("t4_opnd1", issueOperand1, 32'h55);
        chk("t4_freed", full, 0);
        disp(9, 6, 1, 0, 1, 2, 0, 1); tick();
        idle(); tick();
        chk("t4_refill_rob", issueRob, 6); chk("t4_refill_op", issueOp, 9);

        // Flush with three entries and a held issue register; its broadcast must not matter.
        issueReady = 0; flush = 1; bcast(6, 32'h66); tick();
        idle(); chk("fl_iv", issueValid, 0); chk("fl_full", full, 0);
        issueReady = 1; tick();
        chk("fl_after_iv", issueValid, 0);

        // Stall: issue register held, two ready entries queued (older one at index 1).
        issueReady = 0;
        disp(1, 7, 7, 0, 1, 7, 0, 1); tick();
        disp(1, 1, 11, 0, 1, 12, 0, 1); tick();
        disp(1, 2, 21, 0, 1, 22, 0, 1); tick();
        idle();
        chk("st_hold_rob", issueRob, 7); tick();
        chk("st_hold_opnds", {issueOperand1, issueOperand2}, {32'd7, 32'd7}); tick();
        chk("st_hold_rob2", issueRob, 7);
        issueReady = 1; tick();
`ifdef RS_AGE_ORDER_EN
        chk("st_first", issueRob, 1); tick();
        chk("st_second", issueRob, 2);
`else
        chk("st_first", issueRob, 2); tick();
        chk("st_second", issueRob, 1);
`endif
        tick();
        chk("st_drained", issueValid, 0);

        // Asynchronous reset mid-cycle, then a dispatch on the first edge after release.
        issueReady = 0;
        disp(1, 3, 30, 0, 1, 31, 0, 1); tick();
        idle(); tick();
        chk("ar_pre", issueValid, 1);
        #2 reset = 1; model_clear();
        #1 chk("ar_iv", issueValid, 0); chk("ar_rob", issueRob, 0); chk("ar_full", full, 0);
        tick();
        reset = 0; issueReady = 1;
        disp(2, 4, 40, 0, 1, 41, 0, 1); tick();
        idle(); tick();
        chk("ar_first_iv", issueValid, 1); chk("ar_first_rob", issueRob, 4); chk("ar_first_op1", issueOperand1, 40);
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cdb_reservation_station.md
# cdb_reservation_station

Receive-side consumer of the common data bus: a reservation station that buffers dispatched instructions, snoops every valid CDB broadcast to capture pending source operands by ROB tag, and issues ready instructions to one functional unit (ALU or branch unit) over a valid/ready handshake. It sits between the rename/dispatch stage and a functional unit. Its issued results later return to the CDB through the bus arbiter.

## Interface
Parameters:
- WIDTH, 31, MSB index of data words (32-bit data).
- ROB, 2, MSB index of ROB tags (8 ROB entries).
- CONTROL, 6, MSB index of the operation/control field.
- ENTRIES, 4, number of station entries; power of two, at least 2.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- flush  input  1  synchronous pipeline flush (mispredict); invalidates all entries and the issue register.
- dispatchValid  input  1  dispatch request this cycle.
- dispatchOp  input  CONTROL+1  operation/control bits.
- dispatchRob  input  ROB+1  destination ROB entry of the instruction.
- src1Value, src2Value  input  WIDTH+1  operand values, meaningful when the matching ready bit is 1.
- src1Tag, src2Tag  input  ROB+1  producer ROB tags, meaningful when the ready bit is 0.
- src1Ready, src2Ready  input  1  operand already available.
- full  output  1  all entries valid; a dispatch is ignored while high.
- dataBus  interface  commonDataBus.reservation_station  result, robEntry, validBroadcast.
- issueReady  input  1  functional unit accepts the issue register this cycle.
- issueValid  output  1  issue register holds an instruction.
- issueOp  output  CONTROL+1  issued operation.
- issueRob  output  ROB+1  issued destination ROB entry.
- issueOperand1, issueOperand2  output  WIDTH+1  issued operand values.

## Operation
- Each entry holds: valid, op, rob, and two operands (value, tag, ready).
- Dispatch: when dispatchValid is 1 and full is 0, the lowest-index free entry is written at the clock edge.
  - Bypass, always on: if an operand is not ready and validBroadcast is 1 with robEntry equal to its tag in the same cycle, the operand is written as ready with the value result.
- Wakeup: on every edge with validBroadcast set, every valid entry compares each non-ready operand's tag with robEntry. On a match it captures result and sets ready. Both operands of one entry can wake from the same broadcast.
- Select: an entry is eligible when it is valid with both operands ready. The selection policy is set in Configuration.
- Issue register load: on an edge where issueValid is 0 or issueReady is 1, the selected entry (if any) is copied into the issue register and freed.
  - issueValid is set to 1 if an entry was selected, otherwise 0.
  - While issueValid is 1 and issueReady is 0, all issue outputs hold stable.
- full is combinational from the current valid bits. A free occurring in the same cycle does not unblock a dispatch in that cycle.
- Flush takes priority over dispatch, wakeup and issue on the same edge. After the edge, all entries and issueValid are 0.
- Reset values: all entry valid bits 0, issueValid 0, full 0; issueOp, issueRob and the operand outputs are 0.

## Timing
- Dispatch with both operands ready at edge E0 gives issueValid=1 after E0+1 (latency 1 cycle).
- Broadcast sampled at edge Eb wakes the last pending operand; issueValid=1 after Eb+1 if the issue register is free.
- A dispatch that is bypassed at E0 behaves as if ready at dispatch: issue after E0+1.
- Sustained throughput is 1 issue per cycle while issueReady is held at 1.
- Reset asserted mid-operation clears state immediately, without waiting for clk. The first dispatch is accepted on the first edge after reset deasserts.

## Configuration
- RS_AGE_ORDER_EN defined: each entry carries an age counter ($clog2(ENTRIES) bits).
  - A dispatched entry gets age 0. All other valid entries increment on each dispatch, saturating.
  - Select picks the eligible entry with the greatest age (oldest first). Ties go to the lower index.
- RS_AGE_ORDER_EN undefined: no age state; select picks the lowest-index eligible entry.

## Test plan
- Reset, then dispatch op=5, rob=3, src1=10 ready, src2=20 ready, issueReady=1 -> one cycle later issueValid=1, issueOp=5, issueRob=3, operands 10/20; full=0.
- Dispatch rob=1 with src1Tag=6 not ready; two cycles later broadcast robEntry=6, result=0xDEAD -> issue after the next edge with issueOperand1=0xDEAD.
- Dispatch src1Tag=2 not ready in the same cycle as broadcast robEntry=2, result=7 -> captured via bypass; issue one cycle later with operand 7.
- Fill 4 entries with unready operands -> full=1; a fifth dispatch is dropped. A broadcast waking entry 0 frees it -> full=0 and the next dispatch fills index 0.
- Hold issueReady=0 with two ready entries -> issue outputs stay stable. Raise issueReady -> the second entry issues the next cycle. With RS_AGE_ORDER_EN, the older entry issues first even at the higher index.
- Assert flush with 3 valid entries and issueValid=1 -> the next cycle has all entries free, issueValid=0, full=0. A broadcast in the flush cycle has no effect.
